data_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 256 x 8-bit single-cycle data memory. It sits between the CPU datapath (port 0) and a secondary master such as a loader or debug port (port 1). It owns the memory's `mem_write`, `addr` and `write_data` inputs, serialises accesses with round-robin fairness, and returns read data to each requester through a req/gnt/done handshake.

---
 rtl/data_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Round-robin two-port arbiter and access sequencer for a
//                single-cycle data memory (sample / ACCESS / DONE).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACCESS = 2'd1;
    localparam logic [1:0] C_ST_DONE   = 2'd2;

    logic [1:0]    r_state, w_state_d;
    logic          r_sel,   w_sel_d;
    logic          r_we,    w_we_d;
    logic [AW-1:0] r_addr,  w_addr_d;
    logic [DW-1:0] r_wdata, w_wdata_d;
    logic          r_prio,  w_prio_d;
    logic [DW-1:0] r_rdata0, w_rdata0_d;
    logic [DW-1:0] r_rdata1, w_rdata1_d;
    logic          w_pick;
    logic [DW-1:0] w_result;

    always_comb begin
        w_state_d  = r_state;
        w_sel_d    = r_sel;
        w_we_d     = r_we;
        w_addr_d   = r_addr;
        w_wdata_d  = r_wdata;
        w_prio_d   = r_prio;
        w_rdata0_d = r_rdata0;
        w_rdata1_d = r_rdata1;
        // Contention goes to the pointer; a lone request wins outright.
        w_pick     = (req0 && req1) ? r_prio : req1;
        w_result   = r_we ? r_wdata : mem_rdata;

        case (r_state)
            C_ST_IDLE: begin
                if (req0 || req1) begin
                    w_state_d = C_ST_ACCESS;
                    w_sel_d   = w_pick;
                    w_we_d    = w_pick ? we1    : we0;
                    w_addr_d  = w_pick ? addr1  : addr0;
                    w_wdata_d = w_pick ? wdata1 : wdata0;
                end
            end
            C_ST_ACCESS: begin
                if (r_sel) w_rdata1_d = w_result;
                else       w_rdata0_d = w_result;
                w_prio_d  = ~r_sel;
                w_state_d = C_ST_DONE;
            end
            C_ST_DONE: begin
                w_state_d = C_ST_IDLE;
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_ST_IDLE;
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_prio   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state  <= w_state_d;
            r_sel    <= w_sel_d;
            r_we     <= w_we_d;
            r_addr   <= w_addr_d;
            r_wdata  <= w_wdata_d;
            r_prio   <= w_prio_d;
            r_rdata0 <= w_rdata0_d;
            r_rdata1 <= w_rdata1_d;
        end
    end

    assign gnt0      = (r_state == C_ST_ACCESS) && !r_sel;
    assign gnt1      = (r_state == C_ST_ACCESS) &&  r_sel;
    assign done0     = (r_state == C_ST_DONE)   && !r_sel;
    assign done1     = (r_state == C_ST_DONE)   &&  r_sel;
    assign busy      = (r_state != C_ST_IDLE);
    assign mem_write = (r_state == C_ST_ACCESS) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter with an attached
//                memory, directed vectors and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, busy, mem_write;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    data_mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Attached 256x8 memory: combinational read, write on the rising edge.
    logic [7:0] mem [256];
    bit         mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 17);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // Transaction model: m_age is cycles since the grant (-1 when free).
    int         m_age, m_owner, m_prio;
    bit         m_we;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_rd [2];
    logic [7:0] shadow [256];

    function automatic bit m_gnt(input int p);
        return (m_age == 0) && (m_owner == p);
    endfunction

    function automatic bit m_done(input int p);
        return (m_age == 1) && (m_owner == p);
    endfunction

    task automatic model_edge();
        if (rst) begin
            if (m_age == 0 && m_we) shadow[m_addr] = m_wdata;
            m_age = -1; m_owner = 0; m_prio = 0; m_we = 0;
            m_addr = 8'h00; m_wdata = 8'h00; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        end else if (m_age == 0) begin
            if (m_we) begin
                shadow[m_addr] = m_wdata;
                m_rd[m_owner]  = m_wdata;
            end else begin
                m_rd[m_owner] = shadow[m_addr];
            end
            m_prio = 1 - m_owner;
            m_age  = 1;
        end else if (m_age == 1) begin
            m_age = -1;
        end else if (req0 || req1) begin
            m_owner = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
            m_we    = (m_owner == 1) ? we1    : we0;
            m_addr  = (m_owner == 1) ? addr1  : addr0;
            m_wdata = (m_owner == 1) ? wdata1 : wdata0;
            m_age   = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gnt0",      32'(gnt0),      32'(m_gnt(0)));
        chk("gnt1",      32'(gnt1),      32'(m_gnt(1)));
        chk("done0",     32'(done0),     32'(m_done(0)));
        chk("done1",     32'(done1),     32'(m_done(1)));
        chk("busy",      32'(busy),      32'(m_age >= 0));
        chk("mem_write", 32'(mem_write), 32'(m_age == 0 && m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("rdata0",    32'(rdata0),    32'(m_rd[0]));
        chk("rdata1",    32'(rdata1),    32'(m_rd[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic do_access(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        set_port(p, 1'b1, w, a, d);
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if ((p == 0) ? gnt0 : gnt1) got = 1'b1;
        end
        set_port(p, 1'b0, w, a, d);
        chk("gnt_wait", 32'(got), 32'd1);
        if (got) step();
    endtask

    typedef struct {
        bit rst;
        bit r0; bit w0; logic [7:0] a0; logic [7:0] d0;
        bit r1; bit w1; logic [7:0] a1; logic [7:0] d1;
        logic [1:0] gnt; logic [1:0] done; bit busy; bit mw;
        logic [7:0] maddr; logic [7:0] rd0; logic [7:0] rd1;
    } vec_t;

    vec_t vec [17];

    initial begin
        int         seen [$];
        bit         gap_err, prev_busy, any_gnt, pend [2];
        logic [7:0] v8;

        for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 17);
        m_age = -1; m_owner = 0; m_prio = 0; m_we = 0;
        m_addr = 8'h00; m_wdata = 8'h00; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);

        //            rst r0 w0 a0     d0     r1 w1 a1     d1     gnt    done   bsy mw  maddr  rd0    rd1
        vec[0]  = '{1, 1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00};
        vec[1]  = '{1, 1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00};
        vec[2]  = '{0, 1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b01, 2'b00, 1, 0, 8'h20, 8'h00, 8'h00};
        vec[3]  = '{0, 0, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b00, 2'b01, 1, 0, 8'h20, 8'h20, 8'h00};
        vec[4]  = '{0, 0, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b00, 2'b00, 0, 0, 8'h20, 8'h20, 8'h00};
        vec[5]  = '{0, 0, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 2'b10, 2'b00, 1, 1, 8'h20, 8'h20, 8'h00};
        vec[6]  = '{0, 0, 0, 8'h20, 8'h00, 0, 1, 8'h20, 8'hC3, 2'b00, 2'b10, 1, 0, 8'h20, 8'h20, 8'hC3};
        vec[7]  = '{0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h20, 8'h20, 8'hC3};
        vec[8]  = '{0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 1, 0, 8'h20, 8'h20, 8'hC3};
        vec[9]  = '{0, 0, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 1, 0, 8'h20, 8'hC3, 8'hC3};
        vec[10] = '{0, 1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h20, 8'hC3, 8'hC3};
        vec[11] = '{0, 1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 1, 1, 8'h10, 8'hC3, 8'hC3};
        vec[12] = '{0, 0, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 1, 0, 8'h10, 8'h5A, 8'hC3};
        vec[13] = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h10, 8'h5A, 8'hC3};
        vec[14] = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 1, 0, 8'h10, 8'h5A, 8'hC3};
        vec[15] = '{0, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 1, 0, 8'h10, 8'h5A, 8'hC3};
        vec[16] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h10, 8'h5A, 8'hC3};

        for (int i = 0; i < 17; i++) begin
            rst = vec[i].rst;
            set_port(0, vec[i].r0, vec[i].w0, vec[i].a0, vec[i].d0);
            set_port(1, vec[i].r1, vec[i].w1, vec[i].a1, vec[i].d1);
            step();
            chk($sformatf("vec%0d_gnt", i),   32'({gnt1, gnt0}),   32'(vec[i].gnt));
            chk($sformatf("vec%0d_done", i),  32'({done1, done0}), 32'(vec[i].done));
            chk($sformatf("vec%0d_busy", i),  32'(busy),           32'(vec[i].busy));
            chk($sformatf("vec%0d_mw", i),    32'(mem_write),      32'(vec[i].mw));
            chk($sformatf("vec%0d_maddr", i), 32'(mem_addr),       32'(vec[i].maddr));
            chk($sformatf("vec%0d_rd0", i),   32'(rdata0),         32'(vec[i].rd0));
            chk($sformatf("vec%0d_rd1", i),   32'(rdata1),         32'(vec[i].rd1));
        end

        // Continuous dual requests: grants must alternate with single idle gaps.
        set_port(0, 1'b1, 1'b0, 8'h02, 8'h00);
        set_port(1, 1'b1, 1'b0, 8'h03, 8'h00);
        gap_err = 1'b0; prev_busy = 1'b1; any_gnt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt0) seen.push_back(0);
            if (gnt1) seen.push_back(1);
            if (gnt0 || gnt1) any_gnt = 1'b1;
            if (any_gnt && !busy && !prev_busy) gap_err = 1'b1;
            prev_busy = busy;
        end
        chk("dual_grant_count", 32'(seen.size()), 32'd4);
        for (int i = 1; i < seen.size(); i++)
            chk($sformatf("dual_alternate%0d", i), 32'(seen[i] != seen[i-1]), 32'd1);
        chk("dual_idle_gap", 32'(gap_err), 32'd0);
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step();

        // Reset lands on the ACCESS edge of a port-1 write.
        begin
            bit got;
            got = 1'b0;
            set_port(1, 1'b1, 1'b1, 8'h30, 8'h77);
            for (int i = 0; i < 8 && !got; i++) begin
                step();
                if (gnt1) got = 1'b1;
            end
            chk("rst_wr_gnt_wait", 32'(got), 32'd1);
            set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_wr_mem30",  32'(mem[8'h30]), 32'h77);
            chk("rst_wr_done1",  32'(done1),      32'd0);
            chk("rst_wr_rdata1", 32'(rdata1),     32'd0);
            chk("rst_wr_busy",   32'(busy),       32'd0);
            step();
            chk("rst_wr_done1_after", 32'(done1), 32'd0);
        end

        // Read-data hold on port 0 while port 1 keeps the memory busy.
        do_access(0, 1'b0, 8'h01, 8'h00);
        chk("hold_first", 32'(rdata0), 32'h11);
        do_access(1, 1'b1, 8'h01, 8'hEE);
        chk("hold_a1", 32'(rdata0), 32'h11);
        do_access(1, 1'b0, 8'h01, 8'h00);
        chk("hold_a2", 32'(rdata0), 32'h11);
        chk("hold_rd1_new", 32'(rdata1), 32'hEE);
        do_access(1, 1'b1, 8'h30, 8'h12);
        chk("hold_a3", 32'(rdata0), 32'h11);
        do_access(1, 1'b0, 8'h30, 8'h00);
        chk("hold_a4", 32'(rdata0), 32'h11);
        chk("hold_rd1_wr_rd", 32'(rdata1), 32'h12);

        // Randomised traffic against the model on a small address window.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && m_gnt(p)) begin
                    pend[p] = 1'b0;
                    set_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
                end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    v8 = 8'($urandom);
                    set_port(p, 1'b1, 1'($urandom), 8'($urandom_range(0, 7)), v8);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
